// File: rtl/nettlp_cmd_regfile.sv
// rtl/nettlp_cmd_regfile.sv - parametrised NetTLP command-channel register file
typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] dwaddr;
    logic [31:0] data;
    logic [15:0] udp_check;
} NETTLP_CMD_T;

typedef struct packed {
    logic        data_valid;
    NETTLP_CMD_T pkt;
} FIFO_NETTLP_CMD_T;

module nettlp_cmd_regfile #(
    parameter int                     NUM_REGS   = 16,
    parameter logic [32*NUM_REGS-1:0] REG_INIT   = '0,
    parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
    parameter bit                     WR_ACK     = 1'b1,
    parameter int                     BUBBLE_CNT = 5,
    parameter logic [31:0]            ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fifo_cmd_i_rd_en,
    input  logic                   fifo_cmd_i_empty,
    input  FIFO_NETTLP_CMD_T       fifo_cmd_i_dout,
    output logic                   fifo_cmd_o_wr_en,
    input  logic                   fifo_cmd_o_full,
    output FIFO_NETTLP_CMD_T       fifo_cmd_o_din,
    output logic [32*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]    reg_wr_pulse,
    output logic [15:0]            cnt_rd,
    output logic [15:0]            cnt_wr,
    output logic [15:0]            cnt_err
);
    localparam logic [7:0] NETTLP_OPC_REG_RD = 8'h01;
    localparam logic [7:0] NETTLP_OPC_REG_WR = 8'h02;
    localparam int         AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_FETCH, S_EXEC, S_SEND, S_BUBBLE} state_t;
    state_t r_state, w_next;

    FIFO_NETTLP_CMD_T r_cmd;
    FIFO_NETTLP_CMD_T r_din;
    logic [31:0]      r_regs [NUM_REGS];
    logic [31:0]      r_resp_data;
    logic [3:0]       r_bub_cnt;
    logic             r_rd_en, r_wr_en;
    logic [NUM_REGS-1:0] r_pulse;
    logic [15:0]      r_cnt_rd, r_cnt_wr, r_cnt_err;

    logic             w_in_range, w_ro, w_is_rd, w_is_wr, w_has_resp, w_bub_last;
    logic [AW-1:0]    w_idx;
    logic [31:0]      w_cur;
    FIFO_NETTLP_CMD_T w_resp;

    // Register byte order is the reverse of packet byte order.
    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_in_range = r_cmd.pkt.dwaddr < 32'(NUM_REGS);
    assign w_idx      = r_cmd.pkt.dwaddr[AW-1:0];
    assign w_cur      = r_regs[w_idx];
    assign w_ro       = RO_MASK[w_idx];
    assign w_is_rd    = r_cmd.pkt.opcode == NETTLP_OPC_REG_RD;
    assign w_is_wr    = r_cmd.pkt.opcode == NETTLP_OPC_REG_WR;
    assign w_has_resp = w_is_rd || (w_is_wr && WR_ACK);
    assign w_bub_last = r_bub_cnt == 4'(BUBBLE_CNT - 1);

    always_comb begin
        w_resp               = r_cmd;
        w_resp.pkt.data      = r_resp_data;
        w_resp.pkt.udp_check = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Silent commands pass through HOLD so the next head is examined two cycles after its pop.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!fifo_cmd_i_empty) w_next = fifo_cmd_i_dout.data_valid ? S_FETCH : S_HOLD;
            S_HOLD:   w_next = S_IDLE;
            S_FETCH:  if (!fifo_cmd_i_empty) w_next = S_EXEC;
            S_EXEC:   w_next = w_has_resp ? S_SEND : S_HOLD;
            S_SEND:   if (!fifo_cmd_o_full) w_next = (BUBBLE_CNT == 0) ? S_IDLE : S_BUBBLE;
            S_BUBBLE: if (!fifo_cmd_o_full && w_bub_last) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cmd       <= '0;
            r_din       <= '0;
            r_resp_data <= '0;
            r_bub_cnt   <= '0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_pulse     <= '0;
            r_cnt_rd    <= '0;
            r_cnt_wr    <= '0;
            r_cnt_err   <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= REG_INIT[32*i +: 32];
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_pulse <= '0;
            case (r_state)
                S_IDLE: if (!fifo_cmd_i_empty && !fifo_cmd_i_dout.data_valid) r_rd_en <= 1'b1;
                S_FETCH: if (!fifo_cmd_i_empty) begin
                    r_cmd   <= fifo_cmd_i_dout;
                    r_rd_en <= 1'b1;
                end
                S_EXEC: begin
                    if (w_is_rd) begin
                        if (w_in_range) begin
                            r_resp_data <= bswap(w_cur);
                            r_cnt_rd    <= sat_inc(r_cnt_rd);
                        end else begin
                            r_resp_data <= bswap(ERR_DATA);
                            r_cnt_err   <= sat_inc(r_cnt_err);
                        end
                    end else if (w_is_wr) begin
                        if (w_in_range) begin
                            r_cnt_wr <= sat_inc(r_cnt_wr);
                            if (!w_ro) begin
                                r_regs[w_idx]  <= bswap(r_cmd.pkt.data);
                                r_pulse[w_idx] <= 1'b1;
                                r_resp_data    <= r_cmd.pkt.data;
                            end else begin
                                r_resp_data <= bswap(w_cur);
                            end
                        end else begin
                            r_resp_data <= bswap(ERR_DATA);
                            r_cnt_err   <= sat_inc(r_cnt_err);
                        end
                    end else begin
                        r_cnt_err <= sat_inc(r_cnt_err);
                    end
                end
                S_SEND: if (!fifo_cmd_o_full) begin
                    r_wr_en   <= 1'b1;
                    r_din     <= w_resp;
                    r_bub_cnt <= '0;
                end
                S_BUBBLE: if (!fifo_cmd_o_full) begin
                    r_wr_en   <= 1'b1;
                    r_din     <= '0;
                    r_bub_cnt <= r_bub_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[32*g +: 32] = r_regs[g];
    end

    assign fifo_cmd_i_rd_en = r_rd_en;
    assign fifo_cmd_o_wr_en = r_wr_en;
    assign fifo_cmd_o_din   = r_din;
    assign reg_wr_pulse     = r_pulse;
    assign cnt_rd           = r_cnt_rd;
    assign cnt_wr           = r_cnt_wr;
    assign cnt_err          = r_cnt_err;
endmodule

// File: tb/tb_nettlp_cmd_regfile.sv
// tb/tb_nettlp_cmd_regfile.sv - scoreboard bench for nettlp_cmd_regfile
module tb_nettlp_cmd_regfile;
    localparam logic [7:0]   OPC_RD  = 8'h01;
    localparam logic [7:0]   OPC_WR  = 8'h02;
    localparam logic [7:0]   OPC_BAD = 8'h7F;
    localparam int           BUB     = 5;
    localparam logic [127:0] INIT    = {32'hAABBCCDD, 32'h00000000, 32'h11223344, 32'h01234567};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic        rst_a, rst_b, full_a, full_b;
    logic        rd_en_a, rd_en_b, wr_en_a, wr_en_b;
    logic        empty_a = 1'b1, empty_b = 1'b1;
    logic [88:0] dout_a = '0, dout_b = '0, din_a, din_b;
    logic [127:0] reg_q_a, reg_q_b;
    logic [3:0]  pulse_a, pulse_b;
    logic [15:0] cnt_rd_a, cnt_wr_a, cnt_err_a, cnt_rd_b, cnt_wr_b, cnt_err_b;

    logic [88:0] in_q_a[$], in_q_b[$], exp_q_a[$];
    int          rd_t_b[$];
    int          push_cnt_a = 0, push_cnt_b = 0;
    int          pulse_cnt_a [4] = '{0, 0, 0, 0};

    nettlp_cmd_regfile #(.NUM_REGS(4), .REG_INIT(INIT), .RO_MASK(4'b0001),
                         .WR_ACK(1'b1), .BUBBLE_CNT(BUB), .ERR_DATA(32'hDEAD_BEEF)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .fifo_cmd_i_rd_en(rd_en_a), .fifo_cmd_i_empty(empty_a), .fifo_cmd_i_dout(dout_a),
        .fifo_cmd_o_wr_en(wr_en_a), .fifo_cmd_o_full(full_a), .fifo_cmd_o_din(din_a),
        .reg_q(reg_q_a), .reg_wr_pulse(pulse_a),
        .cnt_rd(cnt_rd_a), .cnt_wr(cnt_wr_a), .cnt_err(cnt_err_a));

    nettlp_cmd_regfile #(.NUM_REGS(4), .REG_INIT(INIT), .RO_MASK(4'b0000),
                         .WR_ACK(1'b0), .BUBBLE_CNT(0), .ERR_DATA(32'hDEAD_BEEF)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .fifo_cmd_i_rd_en(rd_en_b), .fifo_cmd_i_empty(empty_b), .fifo_cmd_i_dout(dout_b),
        .fifo_cmd_o_wr_en(wr_en_b), .fifo_cmd_o_full(full_b), .fifo_cmd_o_din(din_b),
        .reg_q(reg_q_b), .reg_wr_pulse(pulse_b),
        .cnt_rd(cnt_rd_b), .cnt_wr(cnt_wr_b), .cnt_err(cnt_err_b));

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        empty_a = (in_q_a.size() == 0);
        dout_a  = empty_a ? '0 : in_q_a[0];
        empty_b = (in_q_b.size() == 0);
        dout_b  = empty_b ? '0 : in_q_b[0];
    endtask

    // Input FIFO models: pop on rd_en, head visible before the next edge.
    always @(negedge clk) begin
        if (rd_en_a && in_q_a.size() > 0) in_q_a.delete(0);
        if (rd_en_b && in_q_b.size() > 0) in_q_b.delete(0);
        #1 refresh();
    end

    always @(negedge clk) begin
        if (wr_en_a) begin
            push_cnt_a++;
            n_tests++;
            assert (exp_q_a.size() != 0) else begin
                n_fail++;
                $error("FAIL push_a_expected: observed push %0h expected none", din_a);
            end
            if (exp_q_a.size() != 0) begin
                chk("push_a_word", din_a, exp_q_a[0]);
                exp_q_a.delete(0);
            end
        end
        if (wr_en_b) push_cnt_b++;
        if (rd_en_b) rd_t_b.push_back(cyc);
        for (int i = 0; i < 4; i++) if (pulse_a[i]) pulse_cnt_a[i]++;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    function automatic logic [88:0] mk(logic dv, logic [7:0] op, logic [31:0] a,
                                       logic [31:0] d, logic [15:0] u);
        return {dv, op, a, d, u};
    endfunction

    task automatic send_a(logic [88:0] c, bit resp, logic [31:0] rdata);
        in_q_a.push_back(c);
        if (resp) begin
            exp_q_a.push_back({c[88:48], rdata, 16'h0000});
            repeat (BUB) exp_q_a.push_back('0);
        end
        refresh();
    endtask

    task automatic drain_a(string tag);
        int t = 0;
        while ((exp_q_a.size() != 0 || in_q_a.size() != 0) && t < 300) begin
            tick(1);
            t++;
        end
        chk({tag, "_drained"}, 128'(t < 300), 128'(1));
        tick(4);
    endtask

    logic [3:0] rd_seq, wr_seq;
    int         n0, t;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; full_a = 1'b0; full_b = 1'b0;
        tick(3);
        chk("rst_rd_en", rd_en_a, 0);
        chk("rst_wr_en", wr_en_a, 0);
        chk("rst_din", din_a, 0);
        chk("rst_reg_q", reg_q_a, INIT);
        chk("rst_pulse", pulse_a, 0);
        chk("rst_counters", {cnt_rd_a, cnt_wr_a, cnt_err_a}, 0);
        chk("rst_b_reg_q", reg_q_b, INIT);
        rst_a = 1'b1; rst_b = 1'b1;
        tick(2);

        send_a(mk(1'b1, OPC_RD, 32'd0, 32'h0, 16'h1234), 1'b1, 32'h67452301);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            rd_seq[k] = rd_en_a;
            wr_seq[k] = wr_en_a;
        end
        chk("rd_latency_rd_en", rd_seq, 4'b0010);
        chk("rd_latency_wr_en", wr_seq, 4'b1000);
        drain_a("rd0");
        chk("cnt_rd_after_rd0", cnt_rd_a, 1);

        send_a(mk(1'b1, OPC_WR, 32'd2, 32'hC0A80A03, 16'h55AA), 1'b1, 32'hC0A80A03);
        tick(2);
        chk("wr_before_update", reg_q_a[95:64], 32'h0);
        tick(1);
        chk("wr_reg_q_word2", reg_q_a[95:64], 32'h030AA8C0);
        chk("wr_pulse_cycle3", pulse_a, 4'b0100);
        drain_a("wr2");
        chk("wr_pulse_count", pulse_cnt_a[2], 1);
        chk("cnt_wr_after_wr2", cnt_wr_a, 1);
        send_a(mk(1'b1, OPC_RD, 32'd2, 32'h0, 16'h0), 1'b1, 32'hC0A80A03);
        drain_a("rd2");
        chk("cnt_rd_after_rd2", cnt_rd_a, 2);

        send_a(mk(1'b1, OPC_WR, 32'd0, 32'hFFFFFFFF, 16'h0), 1'b1, 32'h67452301);
        drain_a("ro_wr");
        chk("ro_reg_unchanged", reg_q_a[31:0], 32'h01234567);
        chk("ro_no_pulse", pulse_cnt_a[0], 0);
        chk("cnt_wr_after_ro", cnt_wr_a, 2);

        send_a(mk(1'b1, OPC_RD, 32'd9, 32'h0, 16'h0), 1'b1, 32'hEFBEADDE);
        drain_a("oor");
        chk("cnt_err_oor", cnt_err_a, 1);
        n0 = push_cnt_a;
        send_a(mk(1'b1, OPC_BAD, 32'd1, 32'h0, 16'h0), 1'b0, 32'h0);
        drain_a("bad_opc");
        chk("bad_opc_no_push", push_cnt_a, n0);
        chk("cnt_err_bad_opc", cnt_err_a, 2);

        n0 = push_cnt_a;
        send_a(mk(1'b1, OPC_RD, 32'd3, 32'h0, 16'hBEEF), 1'b1, 32'hDDCCBBAA);
        t = 0;
        while (push_cnt_a < n0 + 2 && t < 50) begin
            tick(1);
            t++;
        end
        chk("bp_reached_bubble", 128'(t < 50), 128'(1));
        full_a = 1'b1;
        tick(20);
        chk("bp_no_push_while_full", push_cnt_a, n0 + 2);
        full_a = 1'b0;
        drain_a("bp");
        chk("bp_total_pushes", push_cnt_a, n0 + 1 + BUB);

        send_a(mk(1'b0, OPC_RD, 32'd0, 32'h0, 16'h0), 1'b0, 32'h0);
        send_a(mk(1'b1, OPC_RD, 32'd1, 32'h0, 16'h0), 1'b1, 32'h44332211);
        drain_a("skip");
        chk("cnt_rd_final", cnt_rd_a, 4);
        chk("scoreboard_empty", exp_q_a.size(), 0);

        in_q_b.push_back(mk(1'b1, OPC_WR, 32'd1, 32'h0A0B0C0D, 16'h0));
        in_q_b.push_back(mk(1'b1, OPC_WR, 32'd2, 32'h11111111, 16'h0));
        in_q_b.push_back(mk(1'b1, OPC_WR, 32'd3, 32'h12345678, 16'h0));
        refresh();
        t = 0;
        while (in_q_b.size() != 0 && t < 100) begin
            tick(1);
            t++;
        end
        tick(4);
        chk("b_pop_count", rd_t_b.size(), 3);
        if (rd_t_b.size() == 3) begin
            chk("b_spacing_1", rd_t_b[1] - rd_t_b[0], 4);
            chk("b_spacing_2", rd_t_b[2] - rd_t_b[1], 4);
        end
        chk("b_regs_written", reg_q_b, {32'h78563412, 32'h11111111, 32'h0D0C0B0A, 32'h01234567});
        chk("b_cnt_wr", cnt_wr_b, 3);
        chk("b_no_push_writes", push_cnt_b, 0);

        in_q_b.push_back(mk(1'b1, OPC_RD, 32'd1, 32'h0, 16'h0));
        refresh();
        tick(3);
        rst_b = 1'b0;
        tick(2);
        rst_b = 1'b1;
        tick(4);
        chk("b_reset_mid_send_no_push", push_cnt_b, 0);
        chk("b_reset_regs_init", reg_q_b, INIT);
        chk("b_reset_counters", {cnt_rd_b, cnt_wr_b, cnt_err_b}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule
